// File: rtl/iter_alu_calc.sv
// Registered calculator datapath: single-cycle logic/add/sub plus iterative signed MUL/DIV.
// Start is taken in IDLE or DONE; results and flags are held until the next done pulse.
module iter_alu_calc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    // Multiplier bits for MUL; dividend shifting out / quotient shifting in for DIV.
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   rem_q;

    logic [WIDTH-1:0]   a_mag, b_mag, sum, dif;
    logic [WIDTH-1:0]   quick_res;
    logic               quick_ovf;
    logic [2*WIDTH-1:0] acc_nx, prod;
    logic [WIDTH:0]     rem_sh;
    logic               quo_bit;
    logic [WIDTH-1:0]   rem_nx, quo_nx, quo_res;
    logic               mul_ovf, div_ovf;

    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
        sum   = a + b;
        dif   = a - b;
        quick_res = '0;
        quick_ovf = 1'b0;
        unique case (op)
            3'd0: begin
                quick_res = sum;
                quick_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                quick_res = dif;
                quick_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2:    quick_res = a & b;
            3'd3:    quick_res = a | b;
            3'd4:    quick_res = a ^ b;
            3'd5:    quick_res = ~a;
            default: quick_res = '0;
        endcase
    end

    // One shift-add step and one restoring-division step; final sign fix-up from the step output.
    always_comb begin
        acc_nx  = mplier_q[0] ? acc_q + mcand_q : acc_q;
        prod    = neg_q ? -acc_nx : acc_nx;
        mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        rem_sh  = {rem_q, mplier_q[WIDTH-1]};
        quo_bit = rem_sh >= {1'b0, divisor_q};
        rem_nx  = quo_bit ? WIDTH'(rem_sh - {1'b0, divisor_q}) : rem_sh[WIDTH-1:0];
        quo_nx  = {mplier_q[WIDTH-2:0], quo_bit};
        quo_res = neg_q ? -quo_nx : quo_nx;
        // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
        div_ovf = !neg_q && quo_nx[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                    if (start) begin
                        if (op < 3'd6) begin
                            result   <= quick_res;
                            overflow <= quick_ovf;
                            div_zero <= 1'b0;
                            done     <= 1'b1;
                            state_q  <= StDone;
                        end else if (op == 3'd7 && b == '0) begin
                            result   <= '0;
                            overflow <= 1'b0;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            state_q   <= StCalc;
                            busy      <= 1'b1;
                            cnt_q     <= CNT_W'(WIDTH);
                            is_div_q  <= op[0];
                            neg_q     <= a[WIDTH-1] ^ b[WIDTH-1];
                            acc_q     <= '0;
                            mcand_q   <= {{WIDTH{1'b0}}, a_mag};
                            mplier_q  <= op[0] ? a_mag : b_mag;
                            divisor_q <= b_mag;
                            rem_q     <= '0;
                        end
                    end
                end
                StCalc: begin
                    acc_q    <= acc_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= is_div_q ? quo_nx : (mplier_q >> 1);
                    rem_q    <= rem_nx;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q  <= StDone;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        div_zero <= 1'b0;
                        result   <= is_div_q ? quo_res : prod[WIDTH-1:0];
                        overflow <= is_div_q ? div_ovf : mul_ovf;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu_calc.sv
// Directed bench for iter_alu_calc: WIDTH=8 instance for ops/handshake/reset, WIDTH=16 for MUL.
`timescale 1ns/1ps
module tb_iter_alu_calc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, start16;
    logic [2:0]  op, op16;
    logic [7:0]  a, b;
    logic [15:0] a16, b16;
    logic        busy, done, overflow, div_zero;
    logic [7:0]  result;
    logic        busy16, done16, overflow16, div_zero16;
    logic [15:0] result16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    iter_alu_calc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .overflow(overflow), .div_zero(div_zero)
    );

    iter_alu_calc #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .overflow(overflow16),
        .div_zero(div_zero16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op on the 8-bit instance; lat is the cycle (after the accept edge) holding done.
    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] xa,
                        input logic [7:0] xb, input int lat, input logic [7:0] er,
                        input logic eo, input logic ed);
        int bad;
        @(negedge clk);
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0;
        bad = 0;
        for (int i = 1; i < lat; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        if (lat > 1) check({tag, "_busy_phase"}, bad, 0);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_off"}, busy, 1'b0);
        check({tag, "_result"}, result, er);
        check({tag, "_ovf"}, overflow, eo);
        check({tag, "_dz"}, div_zero, ed);
    endtask

    initial begin
        int dones, bad;
        reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_ovf", overflow, 1'b0);
        check("rst_dz", div_zero, 1'b0);
        check("rst16_result", result16, 16'h0000);
        reset_n = 1'b1;

        run8("add_ovf",  3'd0, 8'd100, 8'd50, 1, 8'h96, 1'b1, 1'b0);
        run8("sub_ovf",  3'd1, 8'h80,  8'h01, 1, 8'h7F, 1'b1, 1'b0);
        run8("and",      3'd2, 8'hCA,  8'h0F, 1, 8'h0A, 1'b0, 1'b0);
        run8("or",       3'd3, 8'hA0,  8'h05, 1, 8'hA5, 1'b0, 1'b0);
        run8("mul_neg",  3'd6, 8'hF9,  8'h06, 9, 8'hD6, 1'b0, 1'b0);
        run8("mul_ovf",  3'd6, 8'h10,  8'h10, 9, 8'h00, 1'b1, 1'b0);
        run8("div_neg",  3'd7, 8'h9C,  8'h07, 9, 8'hF2, 1'b0, 1'b0);
        run8("div_zero", 3'd7, 8'h05,  8'h00, 1, 8'h00, 1'b0, 1'b1);
        run8("add_clr",  3'd0, 8'h03,  8'h04, 1, 8'h07, 1'b0, 1'b0);
        run8("div_min",  3'd7, 8'h80,  8'hFF, 9, 8'h80, 1'b1, 1'b0);
        run8("div_min1", 3'd7, 8'h80,  8'h01, 9, 8'h80, 1'b0, 1'b0);
        run8("div_pn",   3'd7, 8'd100, 8'hF9, 9, 8'hF2, 1'b0, 1'b0);

        // Start pulse during CALC must be ignored; then back-to-back XOR in the done cycle.
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 8'hF9; b = 8'h06;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin
                start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01;
            end
            if (done === 1'b1) dones++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("hs_no_early_done", dones, 0);
        check("hs_done", done, 1'b1);
        check("hs_result", result, 8'hD6);
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 8'h0F; b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done", done, 1'b1);
        check("b2b_result", result, 8'hF0);
        @(posedge clk); #1;
        check("b2b_single_pulse", done, 1'b0);

        // Reset mid-MUL aborts it.
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 8'h03; b = 8'h03;
        @(posedge clk); #1;
        start = 1'b0;
        check("rmul_busy", busy, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rmul_busy_clr", busy, 1'b0);
        check("rmul_result_clr", result, 8'h00);
        check("rmul_done_clr", done, 1'b0);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rmul_no_done", bad, 0);
        run8("not", 3'd5, 8'h0F, 8'h00, 1, 8'hF0, 1'b0, 1'b0);

        // WIDTH=16 multiply: done 17 cycles after accept.
        @(negedge clk);
        start16 = 1'b1; op16 = 3'd6; a16 = 16'd300; b16 = 16'hFF38;
        @(posedge clk); #1;
        start16 = 1'b0;
        bad = 0;
        for (int i = 1; i < 17; i++) begin
            if (busy16 !== 1'b1 || done16 !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("m16_busy_phase", bad, 0);
        check("m16_done", done16, 1'b1);
        check("m16_result", result16, 16'h15A0);
        check("m16_ovf", overflow16, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iter_alu_calc.md
Name: iter_alu_calc

Overview:
- Parametrised, registered successor to the 8-bit calculator datapath.
- One block holds operand capture, single-cycle logic/arith ops, and multi-cycle signed multiply and divide.
- Uses a start/busy/done handshake with overflow and divide-by-zero flags.
- Sits between operand/opcode registers and the result display/readback path; replaces the old counter-driven repeated-addition multiply.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH+1): width of the internal iteration counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- start  in  1  request; accepted only when block is in IDLE or DONE.
- op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(A), 6 MUL, 7 DIV.
- a  in  WIDTH  signed operand A, captured on accepted start.
- b  in  WIDTH  signed operand B, captured on accepted start.
- busy  out  1  high while a MUL/DIV iteration is in progress.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- result  out  WIDTH  signed result; held until the next done.
- overflow  out  1  signed overflow of the last operation; held with result.
- div_zero  out  1  last operation was DIV with b==0; held with result.

Behaviour:
- Reset (reset_n==0 at a clk edge):
  - State goes to IDLE; busy=0, done=0, result=0, overflow=0, div_zero=0.
  - Any in-flight MUL/DIV is aborted; no done is produced for it.
  - Reset has priority over start.
- States: IDLE, CALC, DONE.
  - IDLE/DONE + start, op 0..5: compute, register outputs, go to DONE; done=1 at T+1 (start sampled at edge T).
  - IDLE/DONE + start, op 6/7: capture a, b, op; go to CALC; load counter=WIDTH; busy=1 from T+1.
  - IDLE/DONE + start, DIV with b==0: no iteration; result=0, div_zero=1, overflow=0, done at T+1.
  - CALC: one iteration per cycle; counter decrements. After WIDTH iterations, go to DONE with done=1 at T+WIDTH+1; busy=0 in that cycle.
  - DONE without start: go to IDLE next cycle. done is high for exactly one cycle.
  - start while in CALC is ignored (not queued).
  - start in the DONE cycle is accepted, giving back-to-back operation.
- Arithmetic (two's complement, WIDTH bits):
  - ADD/SUB: result is the low WIDTH bits. overflow=1 if the operand signs make the true result unrepresentable.
  - AND/OR/XOR/NOT: bitwise; overflow=0.
  - MUL: shift-add on magnitudes with a 2*WIDTH accumulator, then sign fix-up. result = low WIDTH bits. overflow=1 if the full product is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - DIV: restoring division on magnitudes, then sign fix-up; quotient truncates toward zero; remainder is discarded.
    - MIN/-1 gives result=MIN, overflow=1.
    - Otherwise overflow=0.
- Flags:
  - overflow and div_zero update only on done; they are cleared on every done that does not set them.
- Operands:
  - a, b, and op are registered on accept. Changes on these inputs during CALC have no effect.
- Unused op encodings: none; all 8 are defined.

Test Plan:
- WIDTH=8, ADD a=100 b=50 -> done at T+1, result=0x96 (-106), overflow=1; then SUB a=-128 b=1 -> result=0x7F, overflow=1.
- MUL a=-7 b=6 -> busy high T+1..T+8, done at T+9, result=0xD6 (-42), overflow=0; MUL a=16 b=16 -> result=0x00, overflow=1.
- DIV a=-100 b=7 -> done at T+9, result=0xF2 (-14); DIV a=5 b=0 -> done at T+1, result=0, div_zero=1; DIV a=-128 b=-1 -> result=0x80, overflow=1.
- Handshake: start pulses at T+3 during a MUL -> ignored, exactly one done. New start (XOR 0x0F^0xFF) in the done cycle -> accepted, result=0xF0 one cycle later.
- Reset: drive reset_n=0 at T+4 of a MUL -> next edge busy=0, result=0, no done. After release, NOT a=0x0F -> result=0xF0, done at T+1.
- WIDTH=16: MUL a=300 b=-200 -> done at T+17, result=0x15A0 (-60000 truncated), overflow=1.
